// File: rtl/spi_write_fifo.sv
// Purpose: SPI write endpoint; operand bytes sent under REGISTER_ADDRESS are queued in a FIFO, STATUS_ADDRESS returns a status byte.
// Latency: a byte is visible on data_out one cycle after operand_valid_in rises; status is valid from the cycle after the opcode rising edge.
// Backpressure: the drain port is valid/ready; pushes into a full FIFO are dropped and latch the sticky overflow_out flag.
//
// Ports:
//   clock_in, reset_in          - system clock, async active-high reset
//   opcode_in/opcode_valid_in   - opcode byte and level valid (high until chip-select release)
//   operand_in/operand_valid_in - operand byte and per-byte valid pulse
//   response_out/_valid_out     - status byte {overflow, 2'b00, count[4:0]} while in STATUS
//   data_out/data_valid_out     - head of FIFO (first-word-fall-through), FIFO not empty
//   data_ready_in               - downstream accepts data_out this cycle
//   overflow_out                - sticky: at least one byte was dropped since the last status read
module spi_write_fifo #(
  parameter logic [7:0] REGISTER_ADDRESS = 8'h10,
  parameter logic [7:0] STATUS_ADDRESS   = 8'h11,
  parameter int         DEPTH            = 16
) (
  input  logic       clock_in,
  input  logic       reset_in,
  input  logic [7:0] opcode_in,
  input  logic       opcode_valid_in,
  input  logic [7:0] operand_in,
  input  logic       operand_valid_in,
  output logic [7:0] response_out,
  output logic       response_valid_out,
  output logic [7:0] data_out,
  output logic       data_valid_out,
  input  logic       data_ready_in,
  output logic       overflow_out
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    STATUS = 2'd2
  } state_t;

  state_t        state;
  logic          opcode_valid_q;
  logic          operand_valid_q;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    mem [DEPTH];

  logic opcode_rise;
  logic opcode_fall;
  logic operand_rise;
  logic full;
  logic push_req;
  logic push;
  logic pop;
  logic drop;
  logic [4:0] count_ext;
  logic [7:0] status_byte;

  // Edge detection against a one-cycle registered copy of each valid.
  assign opcode_rise  = opcode_valid_in & ~opcode_valid_q;
  assign opcode_fall  = ~opcode_valid_in & opcode_valid_q;
  assign operand_rise = operand_valid_in & ~operand_valid_q;

  // Full is judged on the pre-edge count, so a same-cycle pop never
  // makes room for the incoming byte.
  assign full     = (count == FULL_COUNT);
  assign push_req = (state == WRITE) && operand_rise;
  assign push     = push_req && !full;
  assign drop     = push_req && full;

  assign data_valid_out = (count != '0);
  assign pop            = data_valid_out && data_ready_in;
  assign data_out       = mem[rd_ptr];

  assign count_ext   = 5'(count);
  assign status_byte = {overflow_out, 2'b00, count_ext};

  // Storage carries no reset; contents are only observed while count != 0.
  always_ff @(posedge clock_in) begin
    if (push) begin
      mem[wr_ptr] <= operand_in;
    end
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state              <= IDLE;
      opcode_valid_q     <= 1'b0;
      operand_valid_q    <= 1'b0;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      count              <= '0;
      overflow_out       <= 1'b0;
      response_valid_out <= 1'b0;
      response_out       <= 8'h00;
    end else begin
      opcode_valid_q  <= opcode_valid_in;
      operand_valid_q <= operand_valid_in;

      // Pointers wrap naturally at DEPTH (power of two).
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      // A drop in the same cycle as the status-read close keeps the flag set.
      if (drop) begin
        overflow_out <= 1'b1;
      end else if ((state == STATUS) && opcode_fall) begin
        overflow_out <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (opcode_rise) begin
            if (opcode_in == REGISTER_ADDRESS) begin
              state <= WRITE;
            end else if (opcode_in == STATUS_ADDRESS) begin
              state              <= STATUS;
              response_valid_out <= 1'b1;
              response_out       <= status_byte;
            end
          end
        end
        WRITE: begin
          if (opcode_fall) begin
            state <= IDLE;
          end
        end
        STATUS: begin
          if (opcode_fall) begin
            state              <= IDLE;
            response_valid_out <= 1'b0;
          end
        end
        default: begin
          state              <= IDLE;
          response_valid_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_write_fifo.sv
// Purpose: directed bench for spi_write_fifo with hand-computed expectations.
// Latency: inputs change and outputs are sampled on the falling clock edge.
// Backpressure: data_ready_in is driven explicitly per step.
module tb_spi_write_fifo;

  logic       clock_in;
  logic       reset_in;
  logic [7:0] opcode_in;
  logic       opcode_valid_in;
  logic [7:0] operand_in;
  logic       operand_valid_in;
  logic [7:0] response_out;
  logic       response_valid_out;
  logic [7:0] data_out;
  logic       data_valid_out;
  logic       data_ready_in;
  logic       overflow_out;

  int n_checks;
  int n_pass;

  spi_write_fifo #(
    .REGISTER_ADDRESS(8'h10),
    .STATUS_ADDRESS  (8'h11),
    .DEPTH           (16)
  ) dut (
    .clock_in          (clock_in),
    .reset_in          (reset_in),
    .opcode_in         (opcode_in),
    .opcode_valid_in   (opcode_valid_in),
    .operand_in        (operand_in),
    .operand_valid_in  (operand_valid_in),
    .response_out      (response_out),
    .response_valid_out(response_valid_out),
    .data_out          (data_out),
    .data_valid_out    (data_valid_out),
    .data_ready_in     (data_ready_in),
    .overflow_out      (overflow_out)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  task automatic tick();
    @(negedge clock_in);
  endtask

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    n_checks = n_checks + 1;
    assert (observed === expected) begin
      n_pass = n_pass + 1;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic open_op(input logic [7:0] op);
    opcode_in       = op;
    opcode_valid_in = 1'b1;
    tick();
  endtask

  task automatic close_op();
    opcode_valid_in = 1'b0;
    tick();
  endtask

  // Operand pulses are spaced two cycles apart, as SPI byte timing guarantees.
  task automatic send(input logic [7:0] b);
    operand_in       = b;
    operand_valid_in = 1'b1;
    tick();
    operand_valid_in = 1'b0;
    tick();
  endtask

  initial begin
    n_checks         = 0;
    n_pass           = 0;
    reset_in         = 1'b1;
    opcode_in        = 8'h00;
    opcode_valid_in  = 1'b0;
    operand_in       = 8'h00;
    operand_valid_in = 1'b0;
    data_ready_in    = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_data_valid", 16'(data_valid_out), 16'h0);
    check("rst_overflow", 16'(overflow_out), 16'h0);
    check("rst_resp_valid", 16'(response_valid_out), 16'h0);
    check("rst_resp", 16'(response_out), 16'h00);
    reset_in = 1'b0;
    tick();

    // 1: three bytes, then drain one per cycle
    open_op(8'h10);
    send(8'hA1);
    check("t1_first_visible", 16'(data_out), 16'hA1);
    send(8'hB2);
    send(8'hC3);
    close_op();
    check("t1_valid", 16'(data_valid_out), 16'h1);
    check("t1_head", 16'(data_out), 16'hA1);
    data_ready_in = 1'b1;
    check("t1_pop0", 16'(data_out), 16'hA1);
    tick();
    check("t1_pop1", 16'(data_out), 16'hB2);
    tick();
    check("t1_pop2", 16'(data_out), 16'hC3);
    tick();
    check("t1_empty", 16'(data_valid_out), 16'h0);
    data_ready_in = 1'b0;

    // 2: 18 bytes into depth 16, overflow, status reads
    open_op(8'h10);
    for (int i = 0; i < 18; i++) begin
      send(8'(i));
    end
    check("t2_overflow", 16'(overflow_out), 16'h1);
    close_op();
    open_op(8'h11);
    check("t2_resp_valid", 16'(response_valid_out), 16'h1);
    check("t2_status1", 16'(response_out), 16'h90);
    close_op();
    check("t2_resp_drop", 16'(response_valid_out), 16'h0);
    check("t2_ovf_clear", 16'(overflow_out), 16'h0);
    open_op(8'h11);
    check("t2_status2", 16'(response_out), 16'h10);
    close_op();
    data_ready_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t2_drain%0d", i), 16'(data_out), 16'(i));
      tick();
    end
    check("t2_empty", 16'(data_valid_out), 16'h0);
    data_ready_in = 1'b0;

    // 3: unknown opcode stores nothing, empty status
    open_op(8'h22);
    send(8'h55);
    check("t3_resp_valid", 16'(response_valid_out), 16'h0);
    send(8'h66);
    close_op();
    check("t3_no_data", 16'(data_valid_out), 16'h0);
    open_op(8'h11);
    check("t3_status_valid", 16'(response_valid_out), 16'h1);
    check("t3_status", 16'(response_out), 16'h00);
    close_op();

    // 4a: simultaneous push and pop with one byte queued
    open_op(8'h10);
    send(8'h70);
    operand_in       = 8'h77;
    operand_valid_in = 1'b1;
    data_ready_in    = 1'b1;
    tick();
    operand_valid_in = 1'b0;
    data_ready_in    = 1'b0;
    check("t4_swap_head", 16'(data_out), 16'h77);
    check("t4_swap_valid", 16'(data_valid_out), 16'h1);
    tick();
    close_op();
    open_op(8'h11);
    check("t4_count1", 16'(response_out), 16'h01);
    close_op();

    // 4b: push on full with same-cycle pop is still dropped
    open_op(8'h10);
    for (int i = 0; i < 15; i++) begin
      send(8'h80 + 8'(i));
    end
    check("t4_full_no_ovf", 16'(overflow_out), 16'h0);
    operand_in       = 8'h99;
    operand_valid_in = 1'b1;
    data_ready_in    = 1'b1;
    tick();
    operand_valid_in = 1'b0;
    data_ready_in    = 1'b0;
    check("t4_full_ovf", 16'(overflow_out), 16'h1);
    check("t4_full_head", 16'(data_out), 16'h80);
    tick();
    close_op();
    open_op(8'h11);
    check("t4_status", 16'(response_out), 16'h8F);
    close_op();
    data_ready_in = 1'b1;
    for (int i = 0; i < 15; i++) begin
      check($sformatf("t4_drain%0d", i), 16'(data_out), 16'h80 + 16'(i));
      tick();
    end
    check("t4_empty", 16'(data_valid_out), 16'h0);
    data_ready_in = 1'b0;

    // 5: asynchronous reset mid-transaction
    open_op(8'h10);
    send(8'h31);
    check("t5_pre_valid", 16'(data_valid_out), 16'h1);
    #2 reset_in = 1'b1;
    #1;
    check("t5_async_valid", 16'(data_valid_out), 16'h0);
    check("t5_async_resp", 16'(response_out), 16'h00);
    check("t5_async_resp_valid", 16'(response_valid_out), 16'h0);
    check("t5_async_ovf", 16'(overflow_out), 16'h0);
    opcode_valid_in = 1'b0;
    tick();
    tick();
    reset_in = 1'b0;
    tick();
    send(8'h42);
    check("t5_ignored", 16'(data_valid_out), 16'h0);
    // A valid opcode held through reset release is decoded as a new rising edge.
    reset_in        = 1'b1;
    opcode_in       = 8'h11;
    opcode_valid_in = 1'b1;
    tick();
    reset_in = 1'b0;
    tick();
    check("t5_release_decode", 16'(response_valid_out), 16'h1);
    check("t5_release_status", 16'(response_out), 16'h00);
    close_op();

    // 6: 20 bytes in batches of 4, pointers wrap
    for (int b = 0; b < 5; b++) begin
      open_op(8'h10);
      for (int j = 0; j < 4; j++) begin
        send(8'hC0 + 8'(b * 4 + j));
      end
      close_op();
      data_ready_in = 1'b1;
      for (int j = 0; j < 4; j++) begin
        check($sformatf("t6_b%0d_%0d", b, j), 16'(data_out), 16'hC0 + 16'(b * 4 + j));
        tick();
      end
      check($sformatf("t6_b%0d_empty", b), 16'(data_valid_out), 16'h0);
      data_ready_in = 1'b0;
    end
    check("t6_no_ovf", 16'(overflow_out), 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
